program_counter: RTL
====================

# program_counter

4-bit program counter with run/halt/single-step control and an optional hardware return-address stack. It sits directly upstream of the 4-bit address select mux. Its `pc` output is the mux's "fetch" input, and the instruction operand nibble is the mux's other input. All state is registered on one clock, and every output comes straight from a flop.

## Interface
- `WIDTH`, default 4: PC width in bits; it matches the address mux width.
- `STACK_DEPTH`, default 4: return-stack entries, a power of two ≥ 2. Used only with `PC_STACK_EN`.

- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `inc` in 1: advance the PC by one (fetch complete).
- `ld` in 1: jump; load `ld_val`.
- `ld_val` in WIDTH: jump target.
- `call` in 1: push PC+1 and load `ld_val`. Requires `PC_STACK_EN`.
- `ret` in 1: pop the top of stack into PC. Requires `PC_STACK_EN`.
- `halt` in 1: enter HALT, taking effect at the next edge.
- `resume` in 1: leave HALT for RUN.
- `step` in 1: while in HALT, permit exactly one PC update.
- `pc` out WIDTH: current program counter.
- `running` out 1: 1 in RUN or STEP.
- `stk_full` out 1: stack holds STACK_DEPTH entries. Tied 0 without the macro.
- `stk_empty` out 1: stack holds 0 entries. Tied 1 without the macro.
- `err` out 1: sticky overflow/underflow flag. Cleared only by `rst`.

## Operation
- **States:** RUN, HALT, STEP (state enum in the shared package).
  - RUN → HALT when `halt`=1.
  - HALT → RUN when `resume`=1 and `halt`=0.
  - HALT → STEP when `step`=1, `resume`=0 and `halt`=0.
  - STEP → HALT unconditionally after one cycle.
  - `halt` beats `resume`/`step` in the same cycle.
- **Update enable:** the PC updates only in RUN or STEP. In HALT, `pc` holds and commands are ignored, not queued.
- **Command priority when enabled:** `ret` > `call` > `ld` > `inc` > hold.
- **PC arithmetic:** `inc` gives pc+1 modulo 2^WIDTH, so 4'hF wraps to 4'h0 silently; no flag is raised.
- **`call`:** pushes (pc+1) mod 2^WIDTH, then pc ← `ld_val`.
  - Stack full: push is dropped, pc ← `ld_val` anyway, `err` ← 1.
- **`ret`:** pc ← top of stack, then pop.
  - Stack empty: pc holds, `err` ← 1.
- **Stack:** LIFO with a pointer of width clog2(STACK_DEPTH)+1. Entries are not cleared on pop; stale data is unobservable.
- **Reset:** `rst` asynchronously forces the following, and overrides all inputs:
  - `pc`=0
  - state=RUN, so `running`=1
  - stack pointer=0, so `stk_empty`=1 and `stk_full`=0
  - `err`=0

## Timing
- **Latency:** a command sampled at edge N appears on `pc` after edge N; one cycle of latency. There is no combinational path from input to output.
- **Halt:** `halt` sampled at edge N stops updates from edge N. A command present in that same cycle while in RUN is still executed, because halt and command are evaluated on the same edge.
- **Step:** `step` in HALT at edge N gives state STEP for cycle N+1. The command at edge N+1 executes, then the state returns to HALT. A single-step spans exactly one PC update.
- **Flags:** `stk_full`/`stk_empty` reflect the pointer after the edge that changed it.
- **Reset mid-operation:** asynchronous assertion clears everything immediately. Release must be synchronous to `clk` externally. The first command is accepted on the first edge after deassertion.

## Configuration
- **`PC_STACK_EN` defined:** the return stack, `call`/`ret` handling, live `stk_full`/`stk_empty` flags and `err` are compiled in.
- **`PC_STACK_EN` undefined:**
  - No stack storage is generated.
  - `call` acts as `ld`.
  - `ret` is ignored.
  - `stk_full`=0, `stk_empty`=1, `err`=0 constant.

## Structure
- **Shared package `cpu_pkg`:**
  - `ADDR_W`=4, the default source for WIDTH.
  - `pc_state_t` enum {RUN, HALT, STEP}.
  - The command priority encoding, a `pc_cmd_t` enum {HOLD, INC, LD, CALL, RET}.
- **Sub-module `pc_stack`:** parameterised LIFO providing push, pop, top, full, empty and the pointer. It is instantiated only under `PC_STACK_EN`. The top level holds the FSM, priority decode, PC register and `err`.

## Test plan
- **Reset and increment:** `rst` pulse, then `inc`=1 for 17 cycles → `pc` goes 0,1,…,F,0,1 with wrap and no `err`; `running`=1 throughout.
- **Jump and hold:** `ld`=1, `ld_val`=4'hA together with `inc`=1 → `pc`=A; the next cycle has no command → `pc` stays A.
- **Halt and step:**
  - `halt` at pc=3 → state HALT; `inc` for 5 cycles leaves `pc`=3.
  - `step` for one cycle, then `inc` → `pc`=4 and the state returns to HALT.
  - `resume` → counting restarts.
- **Call and return (macro on):**
  - At pc=2, `call` with `ld_val`=9 → `pc`=9 and `stk_empty`=0.
  - `ret` → `pc`=3 and `stk_empty`=1.
- **Stack overflow/underflow (macro on):**
  - 5 calls with DEPTH=4 → `stk_full`=1, `err`=1, `pc`=last `ld_val`.
  - After `rst`, `ret` with an empty stack → `pc` holds 0, `err`=1.
- **Asynchronous reset mid-operation:** assert `rst` between edges while pc=7 with the stack non-empty → immediately `pc`=0, `stk_empty`=1, `err`=0, `running`=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: address width, program-counter FSM states and the
// prioritised command encoding used by the program counter.
package cpu_pkg;

   localparam int ADDR_W = 4;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HALT = 2'd1,
      STEP = 2'd2
   } pc_state_t;

   typedef enum logic [2:0] {
      HOLD = 3'd0,
      INC  = 3'd1,
      LD   = 3'd2,
      CALL = 3'd3,
      RET  = 3'd4
   } pc_cmd_t;

   // Highest-priority command wins: ret > call > ld > inc > hold.
   function automatic pc_cmd_t decode_cmd(input logic inc, input logic ld,
                                          input logic call, input logic ret);
      pc_cmd_t cmd;
      cmd = HOLD;
      if (ret)       cmd = RET;
      else if (call) cmd = CALL;
      else if (ld)   cmd = LD;
      else if (inc)  cmd = INC;
      return cmd;
   endfunction

endpackage

// File: rtl/pc_stack.sv
// Return-address LIFO for the program counter. Overflowing pushes and
// underflowing pops are ignored here; the caller flags them.
module pc_stack
   import cpu_pkg::*;
#(
   parameter int WIDTH = ADDR_W,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         top,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   ptr
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    ptr_nxt;

   always_comb begin
      ptr_nxt = ptr;
      if (push && !full)
         ptr_nxt = ptr + PW'(1);
      else if (pop && !empty)
         ptr_nxt = ptr - PW'(1);
   end

   // Flags are registered from the next pointer so they are flop outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr   <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         ptr   <= ptr_nxt;
         full  <= (ptr_nxt == PW'(DEPTH));
         empty <= (ptr_nxt == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full)
         mem[ptr[AW-1:0]] <= din;
   end

   assign top = mem[AW'(ptr - PW'(1))];

endmodule

// File: rtl/program_counter.sv
// Program counter with run/halt/single-step control. Define PC_STACK_EN to
// build in the return-address stack with call/ret and the err flag.
module program_counter
   import cpu_pkg::*;
#(
   parameter int WIDTH       = ADDR_W,
   parameter int STACK_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_val,
   input  logic             call,
   input  logic             ret,
   input  logic             halt,
   input  logic             resume,
   input  logic             step,
   output logic [WIDTH-1:0] pc,
   output logic             running,
   output logic             stk_full,
   output logic             stk_empty,
   output logic             err,
   output logic [1:0]       dbg_state
);

   if (STACK_DEPTH < 2 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("STACK_DEPTH must be a power of two >= 2");
   end

   pc_state_t        state, state_nxt;
   pc_cmd_t          cmd;
   logic [WIDTH-1:0] pc_nxt;
   logic [WIDTH-1:0] pc_inc;

   assign pc_inc    = pc + WIDTH'(1);
   assign dbg_state = state;

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:  if (halt) state_nxt = HALT;
         HALT: begin
            if (halt)        state_nxt = HALT;
            else if (resume) state_nxt = RUN;
            else if (step)   state_nxt = STEP;
         end
         STEP: state_nxt = HALT;
         default: state_nxt = HALT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= RUN;
         running <= 1'b1;
      end else begin
         state   <= state_nxt;
         running <= (state_nxt != HALT);
      end
   end

`ifdef PC_STACK_EN
   logic [WIDTH-1:0]             stk_top;
   logic                         push, pop, err_set;
   logic [$clog2(STACK_DEPTH):0] unused_ptr;

   assign cmd     = (state == HALT) ? HOLD : decode_cmd(inc, ld, call, ret);
   assign push    = (cmd == CALL);
   assign pop     = (cmd == RET);
   assign err_set = (push && stk_full) || (pop && stk_empty);

   pc_stack #(
      .WIDTH (WIDTH),
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (pc_inc),
      .top   (stk_top),
      .full  (stk_full),
      .empty (stk_empty),
      .ptr   (unused_ptr)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          err <= 1'b0;
      else if (err_set) err <= 1'b1;
   end

   always_comb begin
      pc_nxt = pc;
      case (cmd)
         INC:  pc_nxt = pc_inc;
         LD:   pc_nxt = ld_val;
         CALL: pc_nxt = ld_val;
         RET:  if (!stk_empty) pc_nxt = stk_top;
         default: pc_nxt = pc;
      endcase
   end
`else
   logic unused_ret;

   assign unused_ret = ret;
   // Without a stack, call degrades to a plain jump and ret is no command.
   assign cmd       = (state == HALT) ? HOLD : decode_cmd(inc, ld | call, 1'b0, 1'b0);
   assign stk_full  = 1'b0;
   assign stk_empty = 1'b1;
   assign err       = 1'b0;

   always_comb begin
      pc_nxt = pc;
      case (cmd)
         INC:     pc_nxt = pc_inc;
         LD:      pc_nxt = ld_val;
         default: pc_nxt = pc;
      endcase
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pc <= '0;
      else     pc <= pc_nxt;
   end

endmodule
